// File: rtl/fc_pkg.sv
// Shared sizing constants and state encoding for the fully-connected layer scheduler.
package fc_pkg;
    localparam int INPUT_NUM     = 144;
    localparam int OUTPUT_NUM    = 10;
    localparam int DATA_BITS     = 8;
    localparam int BUF_W         = 15;
    localparam int ROM_BIAS_BASE = INPUT_NUM * OUTPUT_NUM;
    localparam int FC_OUT_W      = 18;
    localparam int ACC_W         = 26;
    localparam int DIV_SHIFT     = 5;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        BIAS,
        DRAIN,
        EMIT,
        CLASS
    } fc_state_t;
endpackage

// File: rtl/fc_mac.sv
// Multiply-accumulate datapath: scaled product, running sum, bias add and output saturation.
module fc_mac #(
    parameter int DATA_BITS = fc_pkg::DATA_BITS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                acc_en,
    input  logic                                bias_en,
    input  logic signed [fc_pkg::BUF_W-1:0]     buf_data,
    input  logic signed [DATA_BITS-1:0]         rom_data,
    output logic signed [fc_pkg::FC_OUT_W-1:0]  neuron_out
);
    import fc_pkg::*;

    localparam int PW = BUF_W + DATA_BITS;
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'((2 ** (FC_OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    logic signed [PW-1:0]       prod;
    logic signed [PW-1:0]       prod_adj;
    logic signed [PW-1:0]       prod_div;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W:0]      acc_ext;
    logic signed [ACC_W:0]      bias_ext;
    logic signed [ACC_W:0]      sum;
    logic signed [FC_OUT_W-1:0] sat_val;

    assign prod = buf_data * rom_data;

    // Negative products get a (divisor-1) bias so the arithmetic shift rounds toward zero.
    always_comb begin
        prod_adj = prod;
        if (prod[PW-1]) begin
            prod_adj = prod + PW'((1 << DIV_SHIFT) - 1);
        end
        prod_div = prod_adj >>> DIV_SHIFT;
    end

    assign prod_ext = prod_div;
    assign acc_ext  = acc_q;
    assign bias_ext = rom_data;
    assign sum      = acc_ext + bias_ext;

    always_comb begin
        sat_val = sum[FC_OUT_W-1:0];
        if (sum > SAT_MAX) begin
            sat_val = SAT_MAX[FC_OUT_W-1:0];
        end else if (sum < SAT_MIN) begin
            sat_val = SAT_MIN[FC_OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            neuron_out <= '0;
        end else begin
            if (clear) begin
                acc_q <= '0;
            end else if (acc_en) begin
                acc_q <= acc_q + prod_ext;
            end
            if (bias_en) begin
                neuron_out <= sat_val;
            end
        end
    end
endmodule

// File: rtl/fc_scheduler.sv
// Sequences one fully-connected layer pass: address generation, per-neuron handshake and argmax.
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | issue buffer/weight address j for neuron n
//   BIAS  | issue bias address for neuron n
//   DRAIN | last product lands, bias added, result registered
//   EMIT  | neuron_out presented until out_ready
//   CLASS | one-cycle argmax result
module fc_scheduler #(
    parameter int INPUT_NUM  = fc_pkg::INPUT_NUM,
    parameter int OUTPUT_NUM = fc_pkg::OUTPUT_NUM,
    parameter int DATA_BITS  = fc_pkg::DATA_BITS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic [7:0]                          buf_addr,
    input  logic signed [fc_pkg::BUF_W-1:0]     buf_data,
    output logic [10:0]                         rom_addr,
    input  logic signed [DATA_BITS-1:0]         rom_data,
    output logic signed [fc_pkg::FC_OUT_W-1:0]  neuron_out,
    output logic [3:0]                          neuron_idx,
    output logic                                neuron_valid,
    input  logic                                out_ready,
    output logic [3:0]                          class_out,
    output logic                                class_valid,
    output logic                                busy
);
    import fc_pkg::*;

    localparam int BIAS_BASE = INPUT_NUM * OUTPUT_NUM;

    fc_state_t                  state_q;
    fc_state_t                  state_d;
    logic [7:0]                 j_q;
    logic [3:0]                 n_q;
    logic                       fetch_d_q;
    logic signed [FC_OUT_W-1:0] max_q;
    logic [3:0]                 max_idx_q;
    logic                       last_j;
    logic                       last_n;
    logic                       start_ok;
    logic                       emit_accept;
    logic                       acc_clear;
    logic                       new_max;

    assign last_j      = (j_q == 8'(INPUT_NUM - 1));
    assign last_n      = (n_q == 4'(OUTPUT_NUM - 1));
    assign start_ok    = (state_q == IDLE) && start;
    assign emit_accept = (state_q == EMIT) && out_ready;
    assign acc_clear   = start_ok || (emit_accept && !last_n);
    // Neuron 0 always seeds the max; later neurons must be strictly larger so ties keep the lower index.
    assign new_max     = (n_q == '0) || (neuron_out > max_q);

    assign neuron_valid = (state_q == EMIT);
    assign class_valid  = (state_q == CLASS);
    assign busy         = (state_q != IDLE);
    assign neuron_idx   = n_q;

    always_comb begin
        state_d  = state_q;
        buf_addr = '0;
        rom_addr = '0;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                buf_addr = j_q;
                rom_addr = 11'(int'(n_q) * INPUT_NUM + int'(j_q));
                if (last_j) state_d = BIAS;
            end
            BIAS: begin
                rom_addr = 11'(BIAS_BASE + int'(n_q));
                state_d  = DRAIN;
            end
            DRAIN: state_d = EMIT;
            EMIT: begin
                if (out_ready) state_d = last_n ? CLASS : FETCH;
            end
            CLASS: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            j_q       <= '0;
            n_q       <= '0;
            fetch_d_q <= 1'b0;
            max_q     <= '0;
            max_idx_q <= '0;
            class_out <= '0;
        end else begin
            state_q   <= state_d;
            fetch_d_q <= (state_q == FETCH);
            if (start_ok) begin
                j_q <= '0;
                n_q <= '0;
            end
            if (state_q == FETCH) begin
                j_q <= last_j ? '0 : j_q + 8'd1;
            end
            if (emit_accept) begin
                n_q <= last_n ? '0 : n_q + 4'd1;
                if (new_max) begin
                    max_q     <= neuron_out;
                    max_idx_q <= n_q;
                end
                if (last_n) begin
                    class_out <= new_max ? n_q : max_idx_q;
                end
            end
        end
    end

    fc_mac #(
        .DATA_BITS (DATA_BITS)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .clear      (acc_clear),
        .acc_en     (fetch_d_q),
        .bias_en    (state_q == DRAIN),
        .buf_data   (buf_data),
        .rom_data   (rom_data),
        .neuron_out (neuron_out)
    );
endmodule

// File: tb/tb_fc_scheduler.sv
// Scoreboard bench for fc_scheduler: directed passes push expected neurons/class, a monitor checks them.
module tb_fc_scheduler;
    typedef int vec_t [10];
    typedef struct {
        int idx;
        int val;
        int at;
    } nexp_t;
    typedef struct {
        int cls;
        int at;
    } cexp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               out_ready = 1'b1;
    logic [7:0]         buf_addr;
    logic signed [14:0] buf_data;
    logic [10:0]        rom_addr;
    logic signed [7:0]  rom_data;
    logic signed [17:0] neuron_out;
    logic [3:0]         neuron_idx;
    logic               neuron_valid;
    logic [3:0]         class_out;
    logic               class_valid;
    logic               busy;

    logic signed [14:0] buf_mem [0:143];
    logic signed [7:0]  rom_mem [0:1449];

    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    nexp_t nq[$];
    cexp_t cq[$];
    nexp_t ne;
    cexp_t ce;
    logic               stall_prev = 1'b0;
    logic               class_prev = 1'b0;
    logic signed [17:0] held_out;
    logic [3:0]         held_idx;

    fc_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .buf_addr     (buf_addr),
        .buf_data     (buf_data),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .neuron_out   (neuron_out),
        .neuron_idx   (neuron_idx),
        .neuron_valid (neuron_valid),
        .out_ready    (out_ready),
        .class_out    (class_out),
        .class_valid  (class_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        buf_data <= buf_mem[buf_addr];
        rom_data <= rom_mem[rom_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (neuron_valid && stall_prev) begin
            check("hold_out", int'(neuron_out), int'(held_out));
            check("hold_idx", int'(neuron_idx), int'(held_idx));
        end
        if (neuron_valid && out_ready) begin
            if (nq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_neuron: got idx %0d value %0d, expected none", neuron_idx, neuron_out);
            end else begin
                ne = nq.pop_front();
                check("neuron_val", int'(neuron_out), ne.val);
                check("neuron_idx", int'(neuron_idx), ne.idx);
                check("neuron_cycle", cyc, ne.at);
            end
        end
        stall_prev = neuron_valid && !out_ready;
        held_out   = neuron_out;
        held_idx   = neuron_idx;
        if (class_valid) begin
            if (class_prev) begin
                total++;
                bad++;
                $display("FAIL class_pulse: got class_valid high 2+ cycles, expected 1");
            end
            if (cq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_class: got class %0d, expected none", class_out);
            end else begin
                ce = cq.pop_front();
                check("class_out", int'(class_out), ce.cls);
                check("class_cycle", cyc, ce.at);
                check("class_busy", int'(busy), 1);
            end
        end
        class_prev = class_valid;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_neuron_out"}, int'(neuron_out), 0);
        check({tag, "_neuron_idx"}, int'(neuron_idx), 0);
        check({tag, "_neuron_valid"}, int'(neuron_valid), 0);
        check({tag, "_class_out"}, int'(class_out), 0);
        check({tag, "_class_valid"}, int'(class_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_buf_addr"}, int'(buf_addr), 0);
        check({tag, "_rom_addr"}, int'(rom_addr), 0);
    endtask

    task automatic load_uniform(input int bv, input int wv, input vec_t bias);
        for (int j = 0; j < 144; j++) buf_mem[j] = 15'(bv);
        for (int a = 0; a < 1440; a++) rom_mem[a] = 8'(wv);
        for (int n = 0; n < 10; n++) rom_mem[1440 + n] = 8'(bias[n]);
    endtask

    // Called at posedge+1 of an idle cycle; cycle 0 of the pass is the one after start is sampled.
    task automatic run_pass(input string tag, input vec_t vals, input int cls,
                            input int stall_n, input int stall_len,
                            input int dup_at, input int rst_at);
        int    base;
        int    s_at;
        nexp_t e;
        cexp_t c;
        base = cyc + 1;
        s_at = base + 146 + 147 * stall_n;
        for (int n = 0; n < 10; n++) begin
            e.idx = n;
            e.val = vals[n];
            e.at  = base + 146 + 147 * n + ((n > stall_n) ? stall_len : 0);
            if (n == stall_n) e.at = s_at + stall_len;
            nq.push_back(e);
        end
        c.cls = cls;
        c.at  = base + 1470 + stall_len;
        cq.push_back(c);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (nq.size() != 0 || cq.size() != 0) begin
            if (cyc >= base + 1600) begin
                total++;
                bad++;
                $display("FAIL %s_timeout: got %0d neurons and %0d class pending, expected 0", tag, nq.size(), cq.size());
                nq.delete();
                cq.delete();
                break;
            end
            start     = (cyc == base + dup_at);
            out_ready = !(cyc >= s_at && cyc < s_at + stall_len);
            if (cyc == base) check({tag, "_busy_start"}, int'(busy), 1);
            if (cyc == base + 144) check({tag, "_bias_addr"}, int'(rom_addr), fc_pkg::ROM_BIAS_BASE);
            if (cyc == base + 152) begin
                check({tag, "_buf_addr"}, int'(buf_addr), 5);
                check({tag, "_rom_addr"}, int'(rom_addr), 149);
            end
            if (cyc == base + rst_at) begin
                start = 1'b0;
                rst   = 1'b1;
                nq.delete();
                cq.delete();
                @(posedge clk); #1;
                rst = 1'b0;
                check_reset_outputs({tag, "_abort"});
                return;
            end
            @(posedge clk); #1;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check({tag, "_busy_done"}, int'(busy), 0);
        check({tag, "_idle_buf_addr"}, int'(buf_addr), 0);
        check({tag, "_idle_rom_addr"}, int'(rom_addr), 0);
        check({tag, "_class_hold"}, int'(class_out), cls);
    endtask

    initial begin
        vec_t b;
        vec_t v;
        vec_t b_stall;
        vec_t b_neg;

        b_stall = '{5, -3, 20, 7, 20, -100, 0, 19, 3, 1};
        b_neg   = '{0, 3, -2, 10, 1, 12, -7, 4, 12, 2};
        for (int n = 0; n < 10; n++) b[n] = 0;
        load_uniform(0, 0, b);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // 32 * 1 / 32 = 1 per input, 144 inputs; duplicate start mid-pass is ignored
        for (int n = 0; n < 10; n++) v[n] = 144;
        load_uniform(32, 1, b);
        run_pass("uniform", v, 0, 99, 0, 500, -1);

        // -1/32 truncates to 0, so only the bias n survives
        for (int n = 0; n < 10; n++) begin
            b[n] = n;
            v[n] = n;
        end
        load_uniform(-1, 1, b);
        run_pass("trunc", v, 9, 99, 0, -1, -1);

        for (int n = 0; n < 10; n++) begin
            b[n] = 0;
            v[n] = 131071;
        end
        load_uniform(16383, 127, b);
        run_pass("sat_pos", v, 0, 99, 0, -1, -1);

        for (int n = 0; n < 10; n++) v[n] = -131072;
        load_uniform(16383, -128, b);
        run_pass("sat_neg", v, 0, 99, 0, -1, -1);

        // buf[j] = j, one weight of 32 per neuron at j = 15n+3, neuron 6 carries a large bias
        for (int n = 0; n < 10; n++) b[n] = (n == 6) ? 100 : 0;
        load_uniform(0, 0, b);
        for (int j = 0; j < 144; j++) buf_mem[j] = 15'(j);
        for (int n = 0; n < 10; n++) rom_mem[n * 144 + 15 * n + 3] = 8'sd32;
        v = '{3, 18, 33, 48, 63, 78, 193, 108, 123, 138};
        run_pass("addr", v, 6, 99, 0, -1, -1);

        // 144 + bias; 164 appears at neurons 2 and 4, lowest index wins
        load_uniform(32, 1, b_stall);
        v = '{149, 141, 164, 151, 164, 44, 144, 163, 147, 145};
        run_pass("stall", v, 2, 3, 5, -1, -1);

        // -33/32 truncates to -1; all results negative, max -132 at neurons 5 and 8
        load_uniform(-33, 1, b_neg);
        v = '{-144, -141, -146, -134, -143, -132, -151, -140, -132, -142};
        run_pass("abort", v, 5, 99, 0, -1, 700);
        run_pass("rerun", v, 5, 99, 0, -1, -1);

        repeat (20) @(posedge clk);
        #1;
        check("final_no_extra", nq.size() + cq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fc_scheduler.md
FC_SCHEDULER -- requirements
Module: fc_scheduler

Interface
REQ-001 SHALL have parameters: INPUT_NUM default 144, number of buffered inputs per neuron; OUTPUT_NUM default 10, number of output neurons; DATA_BITS default 8, weight/bias width.
REQ-002 SHALL have ports, one clock, reset synchronous and active-high:
  clk  in  1  sole clock, rising edge
  rst  in  1  synchronous active-high reset
  start  in  1  pulse: 144-entry input buffer full, begin a pass
  buf_addr  out  8  input-buffer read address, 0..INPUT_NUM-1
  buf_data  in  15  signed buffer word, valid 1 cycle after buf_addr
  rom_addr  out  11  weight/bias ROM address; weights n*INPUT_NUM+j, bias INPUT_NUM*OUTPUT_NUM+n
  rom_data  in  DATA_BITS  signed ROM word, valid 1 cycle after rom_addr
  neuron_out  out  18  signed saturated neuron result
  neuron_idx  out  4  index of neuron_out, 0..9
  neuron_valid  out  1  neuron_out/neuron_idx valid
  out_ready  in  1  downstream accepts neuron_out
  class_out  out  4  argmax neuron index
  class_valid  out  1  one-cycle pulse, class_out valid
  busy  out  1  high from accepted start until class_valid

Function
REQ-003 SHALL implement states IDLE, FETCH, BIAS, DRAIN, EMIT, CLASS.
REQ-004 IDLE: start=1 -> FETCH, n=0, j=0, accumulator cleared; start while busy SHALL be ignored.
REQ-005 FETCH: one cycle per j; buf_addr=j, rom_addr=n*144+j; j=143 -> BIAS.
REQ-006 Each cycle after an issued weight address, accumulator += trunc0(buf_data*rom_data/32); division truncates toward zero (-1*1 -> 0, -33*1 -> -1).
REQ-007 Product SHALL be 23-bit signed, accumulator 26-bit signed; no intermediate overflow for any input.
REQ-008 BIAS: rom_addr=1440+n, one cycle; DRAIN: result = acc + bias (sign-extended), saturated to [-131072, 131071], registered into neuron_out.
REQ-009 EMIT: neuron_valid=1, neuron_idx=n; neuron_out/neuron_idx SHALL hold stable while out_ready=0.
REQ-010 EMIT with out_ready=1: n<9 -> FETCH with n+1, j=0, accumulator cleared; n=9 -> CLASS.
REQ-011 Timing with out_ready held 1, start at cycle 0: neuron n valid in cycle 146+147n; class_valid in cycle 1470; busy falls after it; IDLE in 1471.
REQ-012 Argmax SHALL track running max over accepted neuron_out values (signed compare); ties keep lowest index.
REQ-013 CLASS: class_valid=1 for exactly one cycle, class_out held until next class_valid.
REQ-014 buf_addr/rom_addr SHALL be 0 outside FETCH/BIAS.

Reset
REQ-015 rst=1 at any clock edge SHALL force IDLE, n=j=0, accumulator 0, running max cleared, neuron_out=0, neuron_idx=0, neuron_valid=0, class_out=0, class_valid=0, busy=0, addresses 0.
REQ-016 Reset mid-pass SHALL discard the pass; no class_valid for it; start accepted from the first cycle after rst falls.

Structure
REQ-017 INPUT_NUM, OUTPUT_NUM, DATA_BITS, ROM bias base (1440), FC_OUT_W=18, ACC_W=26 and the state enum SHALL live in shared package fc_pkg.
REQ-018 MAC (product, /32 truncation, accumulate, bias add, saturation) SHALL be sub-module fc_mac; FSM, address generation and argmax stay in fc_scheduler.

Verification
REQ-019 All buffer=32, weights=1, bias=0 -> every neuron_out=144, class_out=0 (tie), neuron 0 valid cycle 146, class_valid cycle 1470.
REQ-020 Buffer=-1, weights=1, bias[n]=n -> neuron_out=n (truncation toward zero), class_out=9.
REQ-021 Buffer=16383, weights=127, bias=0 -> neuron_out=131071 (positive saturation); weights=-128 -> -131072.
REQ-022 out_ready=0 for 5 cycles at neuron 3 -> neuron_out/idx stable, neuron 4 and class_valid each delayed by 5 cycles.
REQ-023 Second start pulse at cycle 500 -> ignored, single class_valid at 1470.
REQ-024 rst pulsed at cycle 700 -> all outputs 0 next cycle, no class_valid; new start gives correct full pass.
